ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Owns the single-port WIDTH x RAMSIZE data RAM and shares it between two requesters:
//  port 0 = CPU fetch/execute engine, port 1 = loader/debug port.
//  Sequences one access per cycle with a grant/lock handshake.
//  Lock lets a requester hold the RAM for a short burst, e.g. a 4-byte instruction fetch.
// PARAMETERS
//  WIDTH    8   data width of the RAM and of the wdata/rdata ports
//  RAMSIZE  64  number of RAM words
//  AW       8   address width of addr0/addr1
//  LOCK_MAX 4   maximum consecutive locked accesses before ownership is forcibly released
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      asynchronous, active-low reset
//  req0    in   1      port 0 access request
//  lock0   in   1      port 0 asks to keep ownership after this access
//  we0     in   1      port 0: 1 = write, 0 = read
//  addr0   in   AW     port 0 word address
//  wdata0  in   WIDTH  port 0 write data
//  gnt0    out  1      port 0 owns the RAM this cycle
//  rvalid0 out  1      port 0 read data valid
//  rdata0  out  WIDTH  port 0 read data
//  req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
//  busy    out  1      1 when state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=IDLE; gnt*=0, rvalid*=0, rdata*=0, busy=0;
//    lock counter=0; RR pointer=1. RAM contents are NOT cleared.
//    Reset mid-access drops the access; no rvalid is produced for it.
//  - FSM states: IDLE, OWN0, OWN1. gnt0=(state==OWN0), gnt1=(state==OWN1); Moore outputs, registered.
//  - Access: occurs at the rising edge where state==OWNx and reqx==1.
//    Write: ram[addrx]<=wdatax.
//    Read: rdatax<=ram[addrx], and rvalidx=1 for exactly the following cycle.
//    Read latency is 1 cycle from the access edge.
//  - Out of range (addr>=RAMSIZE): write dropped; read returns 0 with rvalid still pulsed.
//  - Arbitration, evaluated at each edge in IDLE, or when the owner releases:
//    - Only one req high: that port wins.
//    - Both req high: winner per CONFIGURATION.
//    - No req high: next state IDLE.
//    - Arbitration latency: req rising in IDLE -> gnt high the next cycle. No access in the arbitration cycle.
//  - In OWNx:
//    - reqx=0: release, re-arbitrate; no access.
//    - Access with lockx=1 and lock count < LOCK_MAX-1: stay OWNx, count++.
//    - Access with lockx=0, or count reaches LOCK_MAX-1: release, count=0, re-arbitrate.
//      The just-served port competes normally; only it requesting -> it keeps OWNx with no idle cycle.
//  - Throughput: one access per cycle. Owner switch costs no bubble; the new gnt is set at the release edge.
//  - busy mirrors state != IDLE.
//  - Count width: $clog2(LOCK_MAX)+1.
//  - Address is compared at full AW width before indexing.
// CONFIGURATION
//  RAM_ARB_RR_EN defined:
//    round-robin arbitration. On a tie, the port != RR pointer wins.
//    The pointer updates to the owner on every release.
//    Reset pointer=1, so port 0 wins the first tie.
//  RAM_ARB_RR_EN undefined:
//    fixed priority, port 0 always wins ties.
//    The pointer logic is absent.
// TESTING
//  1. Hold reset=0 -> gnt0=gnt1=rvalid*=busy=0, rdata*=0.
//     Release; no req -> stays IDLE.
//  2. Port 1 writes 0xA5 to addr 18 (req1=1, we1=1, lock1=0).
//     Then port 0 reads addr 18 -> rdata0=0xA5 with rvalid0 one cycle after the access edge.
//  3. Port 0 locked burst, lock0=1, addr 0..3, req1 also high ->
//     4 consecutive gnt0 accesses, then gnt1=1 on the next cycle.
//     LOCK_MAX forced release is checked with lock0 held for 6 beats -> release after 4.
//  4. Both req high from IDLE, lock=0, continuous:
//     - RR build: grants alternate 0,1,0,1.
//     - Fixed build: port 0 granted every cycle; port 1 starves until req0=0.
//  5. Read addr 70 (>= RAMSIZE=64) -> rdata=0 with rvalid pulsed.
//     Write to addr 70 -> RAM words 0..63 unchanged.
//  6. Assert reset=0 mid-burst (OWN0, count=2) ->
//     gnt0=0 and rvalid0=0 immediately.
//     After release, re-arbitrates from IDLE; RAM data written before the reset is intact.

Source files
------------

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ram_port_arbiter: single-port RAM shared by two requesters through a grant/lock handshake.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module ram_port_arbiter #(
  parameter int WIDTH    = 8,
  parameter int RAMSIZE  = 64,
  parameter int AW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             lock0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             lock1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic             busy
);
  localparam int IW = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;
  localparam int CW = $clog2(LOCK_MAX) + 1;
  localparam logic [AW:0]   LIMIT = (AW+1)'(RAMSIZE);
  localparam logic [CW-1:0] LAST  = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] ram [RAMSIZE];
  logic             acc0, acc1, in0, in1, rearb, tie1;

  assign acc0 = (state == OWN0) && req0;
  assign acc1 = (state == OWN1) && req1;
  assign in0  = ({1'b0, addr0} < LIMIT);
  assign in1  = ({1'b0, addr1} < LIMIT);
  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign busy = (state != IDLE);

`ifdef RAM_ARB_RR_EN
  logic ptr;

  // A releasing owner counts as the pointer, so the other port takes the tie.
  always_comb begin
    tie1 = ~ptr;
    if (state == OWN0)
      tie1 = 1'b1;
    else if (state == OWN1)
      tie1 = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= 1'b1;
    else if (rearb && state == OWN0)
      ptr <= 1'b0;
    else if (rearb && state == OWN1)
      ptr <= 1'b1;
  end
`else
  assign tie1 = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    count_nx = count;
    rearb    = 1'b0;
    case (state)
      OWN0: begin
        if (!req0 || !lock0 || count == LAST) begin
          rearb    = 1'b1;
          count_nx = '0;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      OWN1: begin
        if (!req1 || !lock1 || count == LAST) begin
          rearb    = 1'b1;
          count_nx = '0;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      default: rearb = 1'b1;
    endcase
    if (rearb) begin
      if (req0 && req1)
        state_nx = tie1 ? OWN1 : OWN0;
      else if (req0)
        state_nx = OWN0;
      else if (req1)
        state_nx = OWN1;
      else
        state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= acc0 && !we0;
      rvalid1 <= acc1 && !we1;
      if (acc0 && !we0)
        rdata0 <= in0 ? ram[addr0[IW-1:0]] : '0;
      if (acc1 && !we1)
        rdata1 <= in1 ? ram[addr1[IW-1:0]] : '0;
    end
  end

  // RAM contents survive reset; accesses are already gated off by the IDLE state.
  always_ff @(posedge clk) begin
    if (acc0 && we0 && in0)
      ram[addr0[IW-1:0]] <= wdata0;
    else if (acc1 && we1 && in1)
      ram[addr1[IW-1:0]] <= wdata1;
  end
endmodule
`default_nettype wire
